// File: rtl/axi_line_adapter.sv
// -----------------------------------------------------------------------------
// axi_line_adapter
//
// Purpose:
//   Bridges cache-line / single-word requests from the miss logic onto an AXI4
//   master port. A write engine and a read engine run independently, so one
//   read and one write may be in flight at the same time. Each request is
//   captured on acceptance, so the requester only has to present it for the
//   valid&ready cycle. Bus errors (SLVERR/DECERR) are reported back through
//   wr_err_o / rd_err_o.
//
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   wr_req_* / wr_addr_i ...          write request (line burst or single beat)
//   wr_done_o, wr_id_o, wr_err_o      write completion pulse, ID and error
//   rd_req_* / rd_addr_i ...          read request (line burst or single beat)
//   rd_valid_o, rd_data_o, rd_id_o,
//   rd_err_o                          read completion pulse, line, ID, error
//   crit_valid_o, crit_data_o         requested beat, as it arrives (bursts)
//   aw_* / w_* / b_* / ar_* / r_*     AXI4 master channels
// -----------------------------------------------------------------------------
module axi_line_adapter #(
    parameter int AXI_DATA_WIDTH      = 64,
    parameter int LINE_WIDTH          = 256,
    parameter int ADDR_WIDTH          = 64,
    parameter int ID_WIDTH            = 10,
    parameter bit CRITICAL_WORD_FIRST = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  logic                        wr_req_valid_i,
    output logic                        wr_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]       wr_addr_i,
    input  logic                        wr_single_i,
    input  logic [2:0]                  wr_size_i,
    input  logic [ID_WIDTH-1:0]         wr_id_i,
    input  logic [LINE_WIDTH-1:0]       wr_data_i,
    input  logic [LINE_WIDTH/8-1:0]     wr_be_i,
    output logic                        wr_done_o,
    output logic [ID_WIDTH-1:0]         wr_id_o,
    output logic                        wr_err_o,

    input  logic                        rd_req_valid_i,
    output logic                        rd_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]       rd_addr_i,
    input  logic                        rd_single_i,
    input  logic [2:0]                  rd_size_i,
    input  logic [ID_WIDTH-1:0]         rd_id_i,
    output logic                        rd_valid_o,
    output logic [LINE_WIDTH-1:0]       rd_data_o,
    output logic [ID_WIDTH-1:0]         rd_id_o,
    output logic                        rd_err_o,
    output logic                        crit_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]   crit_data_o,

    output logic                        aw_valid_o,
    input  logic                        aw_ready_i,
    output logic [ADDR_WIDTH-1:0]       aw_addr_o,
    output logic [7:0]                  aw_len_o,
    output logic [2:0]                  aw_size_o,
    output logic [1:0]                  aw_burst_o,
    output logic [ID_WIDTH-1:0]         aw_id_o,

    output logic                        w_valid_o,
    input  logic                        w_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
    output logic                        w_last_o,

    input  logic                        b_valid_i,
    output logic                        b_ready_o,
    input  logic [ID_WIDTH-1:0]         b_id_i,
    input  logic [1:0]                  b_resp_i,

    output logic                        ar_valid_o,
    input  logic                        ar_ready_i,
    output logic [ADDR_WIDTH-1:0]       ar_addr_o,
    output logic [7:0]                  ar_len_o,
    output logic [2:0]                  ar_size_o,
    output logic [1:0]                  ar_burst_o,
    output logic [ID_WIDTH-1:0]         ar_id_o,

    input  logic                        r_valid_i,
    output logic                        r_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
    input  logic [1:0]                  r_resp_i,
    input  logic                        r_last_i,
    input  logic [ID_WIDTH-1:0]         r_id_i
);

    localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
    localparam int BEATS      = LINE_WIDTH / AXI_DATA_WIDTH;
    localparam int OFF        = $clog2(BEAT_BYTES);
    localparam int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W      = 9;

    localparam logic [7:0]            BURST_LEN  = 8'(BEATS - 1);
    localparam logic [2:0]            BEAT_SIZE  = 3'(OFF);
    localparam logic [1:0]            BURST_INCR = 2'b01;
    localparam logic [1:0]            BURST_WRAP = 2'b10;
    localparam logic [IDX_W-1:0]      LANE_MASK  = IDX_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK  = ~ADDR_WIDTH'(BEAT_BYTES - 1);
    localparam bit                    USE_WRAP   = CRITICAL_WORD_FIRST && (BEATS > 1);

    typedef enum logic [1:0] {W_IDLE, W_SEND, W_WAIT_B} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT_AR, R_RECV} rd_state_e;

    // =========================================================================
    // Write engine
    // =========================================================================
    wr_state_e                 wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0]     wr_addr_q;
    logic                      wr_single_q;
    logic [2:0]                wr_size_q;
    logic [ID_WIDTH-1:0]       wr_id_q;
    logic [LINE_WIDTH-1:0]     wr_data_q;
    logic [LINE_WIDTH/8-1:0]   wr_be_q;
    logic                      aw_done_q;
    logic                      w_done_q;
    logic [IDX_W-1:0]          w_cnt_q;
    logic                      wr_done_q;
    logic [ID_WIDTH-1:0]       wr_id_out_q;
    logic                      wr_err_q;

    logic                      wr_accept;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      b_hs;
    logic                      w_beat_last;
    logic [IDX_W-1:0]          wr_req_lane;
    logic [IDX_W-1:0]          w_lane;

    assign wr_accept   = wr_req_valid_i && wr_req_ready_o;
    assign aw_hs       = aw_valid_o && aw_ready_i;
    assign w_hs        = w_valid_o && w_ready_i;
    assign b_hs        = b_valid_i && b_ready_o;
    assign wr_req_lane = wr_addr_q[OFF +: IDX_W] & LANE_MASK;
    assign w_beat_last = wr_single_q || (w_cnt_q == LANE_MASK);
    assign w_lane      = wr_single_q ? wr_req_lane : w_cnt_q;

    // Burst writes always start at the line base; a single beat keeps its
    // exact address and size so partial stores reach the slave untouched.
    assign aw_addr_o  = wr_single_q ? wr_addr_q : (wr_addr_q & LINE_MASK);
    assign aw_len_o   = wr_single_q ? 8'd0 : BURST_LEN;
    assign aw_size_o  = wr_single_q ? wr_size_q : BEAT_SIZE;
    assign aw_burst_o = BURST_INCR;
    assign aw_id_o    = wr_id_q;
    assign w_data_o   = wr_data_q[w_lane*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign w_strb_o   = wr_be_q[w_lane*BEAT_BYTES +: BEAT_BYTES];
    assign w_last_o   = w_beat_last;

    assign wr_done_o  = wr_done_q;
    assign wr_id_o    = wr_id_out_q;
    assign wr_err_o   = wr_err_q;

    // Write state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state_q <= W_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
        end
    end

    // Write next state: SEND ends only once both the address and the last
    // data beat have been handshaken, in whichever order the slave takes them.
    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_accept) begin
                    wr_state_d = W_SEND;
                end
            end
            W_SEND: begin
                if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && w_beat_last))) begin
                    wr_state_d = W_WAIT_B;
                end
            end
            W_WAIT_B: begin
                if (b_valid_i) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Write state outputs.
    always_comb begin
        wr_req_ready_o = 1'b0;
        aw_valid_o     = 1'b0;
        w_valid_o      = 1'b0;
        b_ready_o      = 1'b0;
        case (wr_state_q)
            W_IDLE:   wr_req_ready_o = 1'b1;
            W_SEND: begin
                aw_valid_o = !aw_done_q;
                w_valid_o  = !w_done_q;
            end
            W_WAIT_B: b_ready_o = 1'b1;
            default: ;
        endcase
    end

    // Write datapath: request capture, AW/W progress tracking and the
    // registered completion report.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_addr_q   <= '0;
            wr_single_q <= 1'b0;
            wr_size_q   <= '0;
            wr_id_q     <= '0;
            wr_data_q   <= '0;
            wr_be_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            w_cnt_q     <= '0;
            wr_done_q   <= 1'b0;
            wr_id_out_q <= '0;
            wr_err_q    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_addr_q   <= wr_addr_i;
                wr_single_q <= wr_single_i;
                wr_size_q   <= wr_size_i;
                wr_id_q     <= wr_id_i;
                wr_data_q   <= wr_data_i;
                wr_be_q     <= wr_be_i;
                aw_done_q   <= 1'b0;
                w_done_q    <= 1'b0;
                w_cnt_q     <= '0;
            end else begin
                if (aw_hs) begin
                    aw_done_q <= 1'b1;
                end
                if (w_hs) begin
                    w_cnt_q <= w_cnt_q + IDX_W'(1);
                    if (w_beat_last) begin
                        w_done_q <= 1'b1;
                    end
                end
            end
            wr_done_q <= b_hs;
            wr_err_q  <= b_hs && b_resp_i[1];
            if (b_hs) begin
                wr_id_out_q <= wr_id_q;
            end
        end
    end

    // =========================================================================
    // Read engine
    // =========================================================================
    rd_state_e                 rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0]     rd_addr_q;
    logic                      rd_single_q;
    logic [2:0]                rd_size_q;
    logic [ID_WIDTH-1:0]       rd_id_q;
    logic [CNT_W-1:0]          r_cnt_q;
    logic                      r_err_acc_q;
    logic                      rd_valid_q;
    logic [ID_WIDTH-1:0]       rd_id_out_q;
    logic                      rd_err_q;

    logic                      rd_accept;
    logic                      r_hs;
    logic [IDX_W-1:0]          rd_req_lane;
    logic [IDX_W-1:0]          r_lane;
    logic [CNT_W-1:0]          r_expected;
    logic                      r_count_bad;
    logic                      crit_hit;

    assign rd_accept   = rd_req_valid_i && rd_req_ready_o;
    assign r_hs        = r_valid_i && r_ready_o;
    assign rd_req_lane = rd_addr_q[OFF +: IDX_W] & LANE_MASK;
    assign r_expected  = rd_single_q ? CNT_W'(1) : CNT_W'(BEATS);
    assign r_count_bad = (r_cnt_q + CNT_W'(1)) != r_expected;

    // With a wrapping burst the first beat is the requested one and later
    // beats walk upward modulo the line; otherwise beats arrive in lane order.
    always_comb begin
        r_lane = r_cnt_q[IDX_W-1:0] & LANE_MASK;
        if (rd_single_q) begin
            r_lane = rd_req_lane;
        end else if (USE_WRAP) begin
            r_lane = (rd_req_lane + r_cnt_q[IDX_W-1:0]) & LANE_MASK;
        end
    end

    assign crit_hit = !rd_single_q &&
                      (USE_WRAP ? (r_cnt_q == '0) : (r_cnt_q == CNT_W'(rd_req_lane)));

    assign ar_addr_o  = rd_single_q ? rd_addr_q :
                        (USE_WRAP ? (rd_addr_q & BEAT_MASK) : (rd_addr_q & LINE_MASK));
    assign ar_len_o   = rd_single_q ? 8'd0 : BURST_LEN;
    assign ar_size_o  = rd_single_q ? rd_size_q : BEAT_SIZE;
    assign ar_burst_o = (USE_WRAP && !rd_single_q) ? BURST_WRAP : BURST_INCR;
    assign ar_id_o    = rd_id_q;
    assign crit_data_o = r_data_i;

    assign rd_valid_o = rd_valid_q;
    assign rd_id_o    = rd_id_out_q;
    assign rd_err_o   = rd_err_q;

    // Read state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state_q <= R_IDLE;
        end else begin
            rd_state_q <= rd_state_d;
        end
    end

    // Read next state: the slave's r_last ends the transfer even if the beat
    // count is wrong, so a short burst cannot hang the engine.
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE: begin
                if (rd_accept) begin
                    rd_state_d = R_WAIT_AR;
                end
            end
            R_WAIT_AR: begin
                if (ar_ready_i) begin
                    rd_state_d = R_RECV;
                end
            end
            R_RECV: begin
                if (r_valid_i && r_last_i) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Read state outputs.
    always_comb begin
        rd_req_ready_o = 1'b0;
        ar_valid_o     = 1'b0;
        r_ready_o      = 1'b0;
        crit_valid_o   = 1'b0;
        case (rd_state_q)
            R_IDLE:    rd_req_ready_o = 1'b1;
            R_WAIT_AR: ar_valid_o     = 1'b1;
            R_RECV: begin
                r_ready_o    = 1'b1;
                crit_valid_o = r_valid_i && crit_hit;
            end
            default: ;
        endcase
    end

    // Read datapath: request capture, beat placement into the line buffer,
    // error accumulation and the registered completion report.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_addr_q   <= '0;
            rd_single_q <= 1'b0;
            rd_size_q   <= '0;
            rd_id_q     <= '0;
            r_cnt_q     <= '0;
            r_err_acc_q <= 1'b0;
            rd_data_o   <= '0;
            rd_valid_q  <= 1'b0;
            rd_id_out_q <= '0;
            rd_err_q    <= 1'b0;
        end else begin
            if (rd_accept) begin
                rd_addr_q   <= rd_addr_i;
                rd_single_q <= rd_single_i;
                rd_size_q   <= rd_size_i;
                rd_id_q     <= rd_id_i;
                r_cnt_q     <= '0;
                r_err_acc_q <= 1'b0;
            end else if (r_hs) begin
                rd_data_o[r_lane*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= r_data_i;
                if (r_cnt_q != '1) begin
                    r_cnt_q <= r_cnt_q + CNT_W'(1);
                end
                r_err_acc_q <= r_err_acc_q | r_resp_i[1];
            end
            rd_valid_q <= r_hs && r_last_i;
            rd_err_q   <= r_hs && r_last_i && (r_err_acc_q || r_resp_i[1] || r_count_bad);
            if (r_hs && r_last_i) begin
                rd_id_out_q <= rd_id_q;
            end
        end
    end

    // Response IDs and the low response bit carry no information for a
    // single-outstanding master.
    logic unused_inputs;
    assign unused_inputs = ^{b_id_i, r_id_i, b_resp_i[0], r_resp_i[0]};

endmodule

// File: tb/tb_axi_line_adapter.sv
// -----------------------------------------------------------------------------
// tb_axi_line_adapter
//
// Directed bench for axi_line_adapter. The main instance uses the default
// INCR configuration; a second instance with critical-word-first enabled
// shares the request and slave-side inputs and is only driven for one read.
// -----------------------------------------------------------------------------
module tb_axi_line_adapter;

    localparam int DW = 64;
    localparam int LW = 256;
    localparam int AW = 64;
    localparam int IW = 10;

    logic clk_i = 1'b0;
    logic rst_ni;

    always #5 clk_i = ~clk_i;

    logic            wr_req_valid_i, rd_req_valid_i, c_rd_req_valid_i;
    logic [AW-1:0]   wr_addr_i, rd_addr_i;
    logic            wr_single_i, rd_single_i;
    logic [2:0]      wr_size_i, rd_size_i;
    logic [IW-1:0]   wr_id_i, rd_id_i;
    logic [LW-1:0]   wr_data_i;
    logic [LW/8-1:0] wr_be_i;
    logic            aw_ready_i, w_ready_i, b_valid_i, ar_ready_i, r_valid_i, r_last_i;
    logic [IW-1:0]   b_id_i, r_id_i;
    logic [1:0]      b_resp_i, r_resp_i;
    logic [DW-1:0]   r_data_i;

    logic            wr_req_ready_o, wr_done_o, wr_err_o, rd_req_ready_o, rd_valid_o, rd_err_o;
    logic [IW-1:0]   wr_id_o, rd_id_o, aw_id_o, ar_id_o;
    logic [LW-1:0]   rd_data_o;
    logic            crit_valid_o, aw_valid_o, w_valid_o, w_last_o, b_ready_o, ar_valid_o, r_ready_o;
    logic [DW-1:0]   crit_data_o, w_data_o;
    logic [AW-1:0]   aw_addr_o, ar_addr_o;
    logic [7:0]      aw_len_o, ar_len_o;
    logic [2:0]      aw_size_o, ar_size_o;
    logic [1:0]      aw_burst_o, ar_burst_o;
    logic [DW/8-1:0] w_strb_o;

    logic            c_wr_req_ready_o, c_wr_done_o, c_wr_err_o, c_rd_req_ready_o, c_rd_valid_o, c_rd_err_o;
    logic [IW-1:0]   c_wr_id_o, c_rd_id_o, c_aw_id_o, c_ar_id_o;
    logic [LW-1:0]   c_rd_data_o;
    logic            c_crit_valid_o, c_aw_valid_o, c_w_valid_o, c_w_last_o, c_b_ready_o, c_ar_valid_o, c_r_ready_o;
    logic [DW-1:0]   c_crit_data_o, c_w_data_o;
    logic [AW-1:0]   c_aw_addr_o, c_ar_addr_o;
    logic [7:0]      c_aw_len_o, c_ar_len_o;
    logic [2:0]      c_aw_size_o, c_ar_size_o;
    logic [1:0]      c_aw_burst_o, c_ar_burst_o;
    logic [DW/8-1:0] c_w_strb_o;

    axi_line_adapter #(
        .AXI_DATA_WIDTH(DW), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
        .CRITICAL_WORD_FIRST(1'b0)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(wr_req_ready_o),
        .wr_addr_i(wr_addr_i), .wr_single_i(wr_single_i), .wr_size_i(wr_size_i),
        .wr_id_i(wr_id_i), .wr_data_i(wr_data_i), .wr_be_i(wr_be_i),
        .wr_done_o(wr_done_o), .wr_id_o(wr_id_o), .wr_err_o(wr_err_o),
        .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
        .rd_addr_i(rd_addr_i), .rd_single_i(rd_single_i), .rd_size_i(rd_size_i),
        .rd_id_i(rd_id_i), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .rd_id_o(rd_id_o), .rd_err_o(rd_err_o),
        .crit_valid_o(crit_valid_o), .crit_data_o(crit_data_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
        .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o), .aw_id_o(aw_id_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
        .w_strb_o(w_strb_o), .w_last_o(w_last_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_id_i(b_id_i), .b_resp_i(b_resp_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
        .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o), .ar_id_o(ar_id_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
        .r_resp_i(r_resp_i), .r_last_i(r_last_i), .r_id_i(r_id_i)
    );

    axi_line_adapter #(
        .AXI_DATA_WIDTH(DW), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
        .CRITICAL_WORD_FIRST(1'b1)
    ) dut_cwf (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wr_req_valid_i(1'b0), .wr_req_ready_o(c_wr_req_ready_o),
        .wr_addr_i(wr_addr_i), .wr_single_i(wr_single_i), .wr_size_i(wr_size_i),
        .wr_id_i(wr_id_i), .wr_data_i(wr_data_i), .wr_be_i(wr_be_i),
        .wr_done_o(c_wr_done_o), .wr_id_o(c_wr_id_o), .wr_err_o(c_wr_err_o),
        .rd_req_valid_i(c_rd_req_valid_i), .rd_req_ready_o(c_rd_req_ready_o),
        .rd_addr_i(rd_addr_i), .rd_single_i(rd_single_i), .rd_size_i(rd_size_i),
        .rd_id_i(rd_id_i), .rd_valid_o(c_rd_valid_o), .rd_data_o(c_rd_data_o),
        .rd_id_o(c_rd_id_o), .rd_err_o(c_rd_err_o),
        .crit_valid_o(c_crit_valid_o), .crit_data_o(c_crit_data_o),
        .aw_valid_o(c_aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(c_aw_addr_o),
        .aw_len_o(c_aw_len_o), .aw_size_o(c_aw_size_o), .aw_burst_o(c_aw_burst_o), .aw_id_o(c_aw_id_o),
        .w_valid_o(c_w_valid_o), .w_ready_i(w_ready_i), .w_data_o(c_w_data_o),
        .w_strb_o(c_w_strb_o), .w_last_o(c_w_last_o),
        .b_valid_i(b_valid_i), .b_ready_o(c_b_ready_o), .b_id_i(b_id_i), .b_resp_i(b_resp_i),
        .ar_valid_o(c_ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(c_ar_addr_o),
        .ar_len_o(c_ar_len_o), .ar_size_o(c_ar_size_o), .ar_burst_o(c_ar_burst_o), .ar_id_o(c_ar_id_o),
        .r_valid_i(r_valid_i), .r_ready_o(c_r_ready_o), .r_data_i(r_data_i),
        .r_resp_i(r_resp_i), .r_last_i(r_last_i), .r_id_i(r_id_i)
    );

    int total_checks  = 0;
    int passed_checks = 0;

    logic [DW-1:0] wbeat [4];
    logic [DW-1:0] rbeat [4];
    logic [DW-1:0] single_word;

    // One comparison: counts it, and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                               input logic [LW-1:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Advance the given number of clock edges; returns 2ns after the edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk_i);
        #2;
    endtask

    initial begin
        wbeat[0] = 64'h0001_0203_0405_0607;
        wbeat[1] = 64'h1011_1213_1415_1617;
        wbeat[2] = 64'h2021_2223_2425_2627;
        wbeat[3] = 64'h3031_3233_3435_3637;
        rbeat[0] = 64'hA000_0000_0000_00A0;
        rbeat[1] = 64'hB111_1111_1111_11B1;
        rbeat[2] = 64'hC222_2222_2222_22C2;
        rbeat[3] = 64'hD333_3333_3333_33D3;
        single_word = 64'hCAFE_F00D_1234_5678;

        rst_ni = 1'b0;
        wr_req_valid_i = 0; rd_req_valid_i = 0; c_rd_req_valid_i = 0;
        wr_addr_i = '0; rd_addr_i = '0; wr_single_i = 0; rd_single_i = 0;
        wr_size_i = '0; rd_size_i = '0; wr_id_i = '0; rd_id_i = '0;
        wr_data_i = '0; wr_be_i = '0;
        aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; ar_ready_i = 0;
        r_valid_i = 0; r_last_i = 0; b_id_i = '0; r_id_i = '0;
        b_resp_i = '0; r_resp_i = '0; r_data_i = '0;

        // ---------------- reset state ----------------
        applyStimulus(2);
        checkOutput("rst_aw_valid", aw_valid_o, 1'b0);
        checkOutput("rst_w_valid", w_valid_o, 1'b0);
        checkOutput("rst_ar_valid", ar_valid_o, 1'b0);
        checkOutput("rst_b_ready", b_ready_o, 1'b0);
        checkOutput("rst_r_ready", r_ready_o, 1'b0);
        checkOutput("rst_wr_done", wr_done_o, 1'b0);
        checkOutput("rst_rd_valid", rd_valid_o, 1'b0);
        checkOutput("rst_rd_data", rd_data_o, '0);
        checkOutput("rst_crit_valid", crit_valid_o, 1'b0);
        rst_ni = 1'b1;
        #1;
        checkOutput("rel_wr_ready", wr_req_ready_o, 1'b1);
        checkOutput("rel_rd_ready", rd_req_ready_o, 1'b1);
        applyStimulus(1);

        // ---------------- 1: INCR line write, AW delayed ----------------
        wr_req_valid_i = 1; wr_addr_i = 64'h1000; wr_single_i = 0; wr_id_i = 10'h011;
        wr_data_i = {wbeat[3], wbeat[2], wbeat[1], wbeat[0]}; wr_be_i = '1;
        #1;
        checkOutput("t1_wr_ready", wr_req_ready_o, 1'b1);
        applyStimulus(1);
        wr_req_valid_i = 0; w_ready_i = 1;
        for (int k = 0; k < 4; k++) begin
            aw_ready_i = (k == 3);
            #1;
            checkOutput("t1_aw_valid", aw_valid_o, 1'b1);
            checkOutput("t1_w_valid", w_valid_o, 1'b1);
            checkOutput("t1_w_data", w_data_o, wbeat[k]);
            checkOutput("t1_w_last", w_last_o, (k == 3));
            if (k == 0) begin
                checkOutput("t1_aw_addr", aw_addr_o, 64'h1000);
                checkOutput("t1_aw_len", aw_len_o, 8'd3);
                checkOutput("t1_aw_size", aw_size_o, 3'd3);
                checkOutput("t1_aw_burst", aw_burst_o, 2'b01);
                checkOutput("t1_aw_id", aw_id_o, 10'h011);
            end
            applyStimulus(1);
        end
        aw_ready_i = 0;
        #1;
        checkOutput("t1_aw_valid_off", aw_valid_o, 1'b0);
        checkOutput("t1_w_valid_off", w_valid_o, 1'b0);
        checkOutput("t1_b_ready", b_ready_o, 1'b1);
        checkOutput("t1_no_early_done", wr_done_o, 1'b0);
        b_valid_i = 1; b_resp_i = 2'b00;
        applyStimulus(1);
        b_valid_i = 0;
        #1;
        checkOutput("t1_wr_done", wr_done_o, 1'b1);
        checkOutput("t1_wr_err", wr_err_o, 1'b0);
        checkOutput("t1_wr_id", wr_id_o, 10'h011);
        checkOutput("t1_wr_ready_again", wr_req_ready_o, 1'b1);
        applyStimulus(1);
        checkOutput("t1_wr_done_pulse", wr_done_o, 1'b0);

        // ---------------- 2: INCR burst read, critical beat 3 ----------------
        rd_req_valid_i = 1; rd_addr_i = 64'h1018; rd_single_i = 0; rd_id_i = 10'h022;
        #1;
        checkOutput("t2_rd_ready", rd_req_ready_o, 1'b1);
        applyStimulus(1);
        rd_req_valid_i = 0;
        #1;
        checkOutput("t2_ar_valid", ar_valid_o, 1'b1);
        checkOutput("t2_ar_addr", ar_addr_o, 64'h1000);
        checkOutput("t2_ar_burst", ar_burst_o, 2'b01);
        checkOutput("t2_ar_len", ar_len_o, 8'd3);
        checkOutput("t2_ar_size", ar_size_o, 3'd3);
        checkOutput("t2_ar_id", ar_id_o, 10'h022);
        ar_ready_i = 1;
        applyStimulus(1);
        ar_ready_i = 0;
        #1;
        checkOutput("t2_ar_valid_off", ar_valid_o, 1'b0);
        checkOutput("t2_r_ready", r_ready_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            r_valid_i = 1; r_data_i = rbeat[k]; r_last_i = (k == 3); r_resp_i = 2'b00;
            #1;
            checkOutput("t2_crit_valid", crit_valid_o, (k == 3));
            if (k == 3) checkOutput("t2_crit_data", crit_data_o, rbeat[3]);
            applyStimulus(1);
        end
        r_valid_i = 0; r_last_i = 0;
        #1;
        checkOutput("t2_rd_valid", rd_valid_o, 1'b1);
        checkOutput("t2_rd_data", rd_data_o, {rbeat[3], rbeat[2], rbeat[1], rbeat[0]});
        checkOutput("t2_rd_err", rd_err_o, 1'b0);
        checkOutput("t2_rd_id", rd_id_o, 10'h022);
        applyStimulus(1);
        checkOutput("t2_rd_valid_pulse", rd_valid_o, 1'b0);

        // ---------------- 3: critical-word-first WRAP read ----------------
        c_rd_req_valid_i = 1; rd_addr_i = 64'h1010; rd_single_i = 0; rd_id_i = 10'h033;
        #1;
        checkOutput("t3_rd_ready", c_rd_req_ready_o, 1'b1);
        applyStimulus(1);
        c_rd_req_valid_i = 0;
        #1;
        checkOutput("t3_ar_valid", c_ar_valid_o, 1'b1);
        checkOutput("t3_ar_addr", c_ar_addr_o, 64'h1010);
        checkOutput("t3_ar_burst", c_ar_burst_o, 2'b10);
        checkOutput("t3_ar_len", c_ar_len_o, 8'd3);
        ar_ready_i = 1;
        applyStimulus(1);
        ar_ready_i = 0;
        for (int k = 0; k < 4; k++) begin
            r_valid_i = 1; r_data_i = rbeat[k]; r_last_i = (k == 3); r_resp_i = 2'b00;
            #1;
            checkOutput("t3_crit_valid", c_crit_valid_o, (k == 0));
            if (k == 0) checkOutput("t3_crit_data", c_crit_data_o, rbeat[0]);
            applyStimulus(1);
        end
        r_valid_i = 0; r_last_i = 0;
        #1;
        checkOutput("t3_rd_valid", c_rd_valid_o, 1'b1);
        checkOutput("t3_rd_data", c_rd_data_o, {rbeat[1], rbeat[0], rbeat[3], rbeat[2]});
        checkOutput("t3_rd_id", c_rd_id_o, 10'h033);
        checkOutput("t3_main_idle", rd_valid_o, 1'b0);
        applyStimulus(1);

        // ---------------- 4: single-beat write to lane 1 ----------------
        wr_req_valid_i = 1; wr_addr_i = 64'h2008; wr_single_i = 1; wr_size_i = 3'd3;
        wr_id_i = 10'h044; wr_be_i = 32'h8421_F00F;
        applyStimulus(1);
        wr_req_valid_i = 0; aw_ready_i = 1; w_ready_i = 1;
        #1;
        checkOutput("t4_aw_addr", aw_addr_o, 64'h2008);
        checkOutput("t4_aw_len", aw_len_o, 8'd0);
        checkOutput("t4_aw_size", aw_size_o, 3'd3);
        checkOutput("t4_aw_burst", aw_burst_o, 2'b01);
        checkOutput("t4_w_data", w_data_o, wbeat[1]);
        checkOutput("t4_w_strb", w_strb_o, 8'hF0);
        checkOutput("t4_w_last", w_last_o, 1'b1);
        applyStimulus(1);
        aw_ready_i = 0;
        #1;
        checkOutput("t4_b_ready", b_ready_o, 1'b1);
        checkOutput("t4_w_valid_off", w_valid_o, 1'b0);
        b_valid_i = 1; b_resp_i = 2'b00;
        applyStimulus(1);
        b_valid_i = 0;
        #1;
        checkOutput("t4_wr_done", wr_done_o, 1'b1);
        checkOutput("t4_wr_id", wr_id_o, 10'h044);
        applyStimulus(1);

        // ---------------- 5: erroring short read alongside a write ----------------
        wr_req_valid_i = 1; wr_addr_i = 64'h3000; wr_single_i = 0; wr_id_i = 10'h055; wr_be_i = '1;
        rd_req_valid_i = 1; rd_addr_i = 64'h3000; rd_single_i = 0; rd_id_i = 10'h066;
        #1;
        checkOutput("t5_wr_ready", wr_req_ready_o, 1'b1);
        checkOutput("t5_rd_ready", rd_req_ready_o, 1'b1);
        applyStimulus(1);
        wr_req_valid_i = 0; rd_req_valid_i = 0;
        aw_ready_i = 1; w_ready_i = 1; ar_ready_i = 1;
        #1;
        checkOutput("t5_ar_valid", ar_valid_o, 1'b1);
        checkOutput("t5_aw_valid", aw_valid_o, 1'b1);
        checkOutput("t5_w_data0", w_data_o, wbeat[0]);
        applyStimulus(1);
        aw_ready_i = 0; ar_ready_i = 0;
        for (int k = 0; k < 3; k++) begin
            r_valid_i = 1; r_data_i = ~rbeat[k]; r_last_i = (k == 2);
            r_resp_i = (k == 1) ? 2'b10 : 2'b00;
            #1;
            checkOutput("t5_w_data", w_data_o, wbeat[k+1]);
            checkOutput("t5_w_last", w_last_o, (k == 2));
            checkOutput("t5_r_ready", r_ready_o, 1'b1);
            applyStimulus(1);
        end
        r_valid_i = 0; r_last_i = 0; r_resp_i = 2'b00;
        #1;
        checkOutput("t5_rd_valid", rd_valid_o, 1'b1);
        checkOutput("t5_rd_err", rd_err_o, 1'b1);
        checkOutput("t5_rd_id", rd_id_o, 10'h066);
        checkOutput("t5_rd_data", rd_data_o, {rbeat[3], ~rbeat[2], ~rbeat[1], ~rbeat[0]});
        checkOutput("t5_b_ready", b_ready_o, 1'b1);
        b_valid_i = 1; b_resp_i = 2'b00;
        applyStimulus(1);
        b_valid_i = 0;
        #1;
        checkOutput("t5_wr_done", wr_done_o, 1'b1);
        checkOutput("t5_wr_err", wr_err_o, 1'b0);
        checkOutput("t5_wr_id", wr_id_o, 10'h055);
        checkOutput("t5_rd_valid_pulse", rd_valid_o, 1'b0);
        applyStimulus(1);

        // ---------------- 6: reset during RECV, then a fresh single read ----------------
        rd_req_valid_i = 1; rd_addr_i = 64'h4000; rd_single_i = 0; rd_id_i = 10'h077;
        applyStimulus(1);
        rd_req_valid_i = 0; ar_ready_i = 1;
        applyStimulus(1);
        ar_ready_i = 0;
        for (int k = 0; k < 2; k++) begin
            r_valid_i = 1; r_data_i = rbeat[k]; r_last_i = 0;
            applyStimulus(1);
        end
        r_valid_i = 0;
        #1;
        checkOutput("t6_in_recv", r_ready_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        checkOutput("t6_rst_r_ready", r_ready_o, 1'b0);
        checkOutput("t6_rst_rd_data", rd_data_o, '0);
        applyStimulus(1);
        checkOutput("t6_rst_rd_valid", rd_valid_o, 1'b0);
        rst_ni = 1'b1;
        #1;
        checkOutput("t6_rel_rd_ready", rd_req_ready_o, 1'b1);
        applyStimulus(1);
        checkOutput("t6_no_rd_valid", rd_valid_o, 1'b0);
        rd_req_valid_i = 1; rd_addr_i = 64'h4010; rd_single_i = 1; rd_size_i = 3'd3; rd_id_i = 10'h088;
        applyStimulus(1);
        rd_req_valid_i = 0;
        #1;
        checkOutput("t6_ar_addr", ar_addr_o, 64'h4010);
        checkOutput("t6_ar_len", ar_len_o, 8'd0);
        checkOutput("t6_ar_burst", ar_burst_o, 2'b01);
        checkOutput("t6_ar_size", ar_size_o, 3'd3);
        ar_ready_i = 1;
        applyStimulus(1);
        ar_ready_i = 0;
        r_valid_i = 1; r_data_i = single_word; r_last_i = 1; r_resp_i = 2'b00;
        #1;
        checkOutput("t6_no_crit_single", crit_valid_o, 1'b0);
        applyStimulus(1);
        r_valid_i = 0; r_last_i = 0;
        #1;
        checkOutput("t6_rd_valid", rd_valid_o, 1'b1);
        checkOutput("t6_rd_data", rd_data_o, {64'h0, single_word, 64'h0, 64'h0});
        checkOutput("t6_rd_err", rd_err_o, 1'b0);
        checkOutput("t6_rd_id", rd_id_o, 10'h088);
        applyStimulus(1);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
